switch_arbiter: RTL and testbench



---
 rtl/switch_arbiter.sv | 125 ++++++++++++
 tb/tb_switch_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_arbiter.sv
// switch_arbiter
//   Central scheduler for a 4-port switch fabric. Each cycle it looks at the
//   head-of-FIFO request of every port and grants a non-conflicting set under
//   a rotating priority. Winners get a one-cycle pop pulse, and their words
//   are delivered to every target egress in the same cycle. An egress that
//   delivered in a cycle is blocked in the following cycle.
//
// Ports
//   clk             clock
//   rst             asynchronous, active-high reset
//   request         bit i: port i FIFO non-empty
//   request_target  port i target mask at [4i+3:4i]
//   request_data    port i head word at [16i+15:16i]
//   grant           bit i: one-cycle pop pulse to port i
//   internal_valid  bit j: word delivered to egress j this cycle
//   internal_data   word for egress j at [16j+15:16j]
//   drop_count      saturating count of granted packets with no deliverable target
module switch_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int WORD_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            request,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]  request_target,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0] request_data,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [NUM_PORTS-1:0]            internal_valid,
    output logic [NUM_PORTS*WORD_WIDTH-1:0] internal_data,
    output logic [7:0]                      drop_count
);

    localparam int PW = $clog2(NUM_PORTS);

    logic [PW-1:0]                   ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]            grant_q, grant_d;
    logic [NUM_PORTS-1:0]            busy_q, busy_d;
    logic [NUM_PORTS*WORD_WIDTH-1:0] data_q, data_d;
    logic [7:0]                      drop_q, drop_d;

    logic [NUM_PORTS-1:0] eff [NUM_PORTS];
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] win;
    logic [NUM_PORTS-1:0] claimed;
    logic [PW-1:0]        idx;
    logic [2:0]           drops;
    logic [8:0]           drop_sum;

    // Effective targets (a port never delivers to itself) and eligibility.
    // A port granted last cycle still shows its old head, so it sits out.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eff[i]  = request_target[i*NUM_PORTS +: NUM_PORTS] & ~(NUM_PORTS'(1) << i);
            elig[i] = request[i] & ~grant_q[i];
        end
    end

    // Rotating scan starting at ptr. Egresses in recovery start out claimed.
    // If the head requester is eligible but blocked, its outputs stay
    // reserved so lower-priority requesters cannot starve it.
    always_comb begin
        claimed = busy_q;
        win     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr_q + PW'(k);
            if (elig[idx] && ((eff[idx] & claimed) == '0)) begin
                win[idx] = 1'b1;
                claimed  = claimed | eff[idx];
            end else if (k == 0 && elig[idx]) begin
                claimed = claimed | eff[idx];
            end
        end
    end

    // Delivery. Winner target sets are disjoint, so each slice has at most
    // one source. Undelivered slices read as zero.
    always_comb begin
        busy_d = '0;
        data_d = '0;
        drops  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win[i]) begin
                busy_d = busy_d | eff[i];
                if (eff[i] == '0) begin
                    drops = drops + 3'd1;
                end
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (eff[i][j]) begin
                        data_d[j*WORD_WIDTH +: WORD_WIDTH] = request_data[i*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        grant_d  = win;
        drop_sum = {1'b0, drop_q} + 9'(drops);
        drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        ptr_d    = (win[ptr_q] || !elig[ptr_q]) ? ptr_q + PW'(1) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign grant          = grant_q;
    assign internal_valid = busy_q;
    assign internal_data  = data_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// Testbench for switch_arbiter: directed vectors, expected responses queued
// by the stimulus and checked by an independent output monitor.
module tb_switch_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  request;
    logic [15:0] request_target;
    logic [63:0] request_data;
    logic [3:0]  grant;
    logic [3:0]  internal_valid;
    logic [63:0] internal_data;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  g;
        logic [3:0]  v;
        logic [63:0] d;
        logic [7:0]  dc;
    } exp_t;

    exp_t sb[$];

    switch_arbiter #(.NUM_PORTS(4), .WORD_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .request        (request),
        .request_target (request_target),
        .request_data   (request_data),
        .grant          (grant),
        .internal_valid (internal_valid),
        .internal_data  (internal_data),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] put(input int j, input logic [15:0] w);
        logic [63:0] r;
        r = 64'(w) << (16 * j);
        return r;
    endfunction

    task automatic push(input string name, input logic [3:0] g, input logic [3:0] v,
                        input logic [63:0] d, input logic [7:0] dc);
        exp_t e;
        e.name = name; e.g = g; e.v = v; e.d = d; e.dc = dc;
        sb.push_back(e);
    endtask

    // Monitor: every cycle with a grant or delivery consumes one expectation.
    always @(negedge clk) begin
        if (!rst && (grant != 4'b0 || internal_valid != 4'b0)) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {56'b0, grant, internal_valid}, 64'h0);
            end else begin
                exp_t        e;
                logic [63:0] mask;
                e = sb.pop_front();
                mask = '0;
                for (int j = 0; j < 4; j++)
                    if (e.v[j]) mask[j*16 +: 16] = 16'hFFFF;
                chk({e.name, ".grant"}, 64'(grant), 64'(e.g));
                chk({e.name, ".valid"}, 64'(internal_valid), 64'(e.v));
                chk({e.name, ".data"}, internal_data & mask, e.d & mask);
                chk({e.name, ".drops"}, 64'(drop_count), 64'(e.dc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        request        = '0;
        request_target = '0;
        request_data   = '0;
    endtask

    task automatic set_port(input int p, input logic [3:0] tgt, input logic [15:0] w);
        request[p]             = 1'b1;
        request_target[p*4 +: 4]  = tgt;
        request_data[p*16 +: 16]  = w;
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".grant"}, 64'(grant), 64'h0);
        chk({name, ".valid"}, 64'(internal_valid), 64'h0);
        chk({name, ".data"}, internal_data, 64'h0);
        chk({name, ".drops"}, 64'(drop_count), 64'h0);
    endtask

    task automatic do_reset(input string name);
        clear_all();
        rst = 1'b1;
        #1;
        chk_zero(name);
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 4; k++) step();
        chk({name, ".pending"}, 64'(sb.size()), 64'h0);
        sb.delete();
    endtask

    initial begin
        clear_all();
        rst = 1'b1;
        #2;
        chk_zero("reset");
        step();
        rst = 1'b0;

        // Single unicast 0 -> 1.
        set_port(0, 4'b0010, 16'h12A5);
        push("unicast", 4'b0001, 4'b0010, put(1, 16'h12A5), 8'd0);
        step();
        clear_all();
        drain("unicast");

        // Contention: ports 0 and 2 both target port 1.
        do_reset("rst_cont");
        set_port(0, 4'b0010, 16'h1211);
        set_port(2, 4'b0010, 16'h4233);
        push("cont0", 4'b0001, 4'b0010, put(1, 16'h1211), 8'd0);
        push("cont1", 4'b0100, 4'b0010, put(1, 16'h4233), 8'd0);
        push("cont2", 4'b0001, 4'b0010, put(1, 16'h1211), 8'd0);
        for (int k = 0; k < 5; k++) step();
        clear_all();
        drain("cont");

        // Broadcast from port 1 against a unicast stream 0 -> 2.
        do_reset("rst_bcast");
        set_port(0, 4'b0100, 16'h14C0);
        set_port(1, 4'b1111, 16'h2FBB);
        push("bc_uni0", 4'b0001, 4'b0100, put(2, 16'h14C0), 8'd0);
        push("bc_bcast", 4'b0010, 4'b1101,
             put(0, 16'h2FBB) | put(2, 16'h2FBB) | put(3, 16'h2FBB), 8'd0);
        push("bc_uni1", 4'b0001, 4'b0100, put(2, 16'h14C0), 8'd0);
        for (int k = 0; k < 3; k++) step();
        request[1] = 1'b0;
        for (int k = 0; k < 2; k++) step();
        clear_all();
        drain("bcast");

        // Parallel non-conflicting unicasts 0 -> 1 and 2 -> 3.
        do_reset("rst_par");
        set_port(0, 4'b0010, 16'h125A);
        set_port(2, 4'b1000, 16'h48C3);
        push("parallel", 4'b0101, 4'b1010, put(1, 16'h125A) | put(3, 16'h48C3), 8'd0);
        step();
        clear_all();
        drain("par");

        // Drop: port 3 targets only itself; 300 grants, counter saturates.
        do_reset("rst_drop");
        set_port(3, 4'b1000, 16'h8877);
        for (int k = 1; k <= 300; k++)
            push($sformatf("drop%0d", k), 4'b1000, 4'b0000, 64'h0, (k > 255) ? 8'd255 : 8'(k));
        for (int k = 0; k < 600; k++) step();
        clear_all();
        drain("drop");
        chk("drop_sat", 64'(drop_count), 64'd255);

        // Reset while a grant is showing aborts it immediately.
        do_reset("rst_mid");
        set_port(0, 4'b0100, 16'h143C);
        step();
        chk("pre_rst_grant", 64'(grant), 64'h1);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        step();
        chk_zero("rst_held");
        rst = 1'b0;
        push("post_rst", 4'b0001, 4'b0100, put(2, 16'h143C), 8'd0);
        step();
        clear_all();
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
